sd_data_tx_ctrl: RTL and testbench



---
 rtl/sd_tx_pkg.sv | 23 ++
 rtl/sd_crc16_sync.sv | 35 +++
 rtl/sd_data_tx_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sd_data_tx_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_tx_pkg.sv
// Shared types and constants for the SD single-block write-data transmitter.
package sd_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_CRC, S_END, S_REL, S_WSTAT, S_STAT, S_BUSY, S_DONE
  } state_e;

  localparam logic [2:0] RES_OK        = 3'd0;
  localparam logic [2:0] RES_CRC_ERR   = 3'd1;
  localparam logic [2:0] RES_WR_ERR    = 3'd2;
  localparam logic [2:0] RES_STAT_TMO  = 3'd3;
  localparam logic [2:0] RES_BUSY_TMO  = 3'd4;
  localparam logic [2:0] RES_UNDERRUN  = 3'd5;
  localparam logic [2:0] RES_BAD_TOKEN = 3'd6;
  localparam logic [2:0] RES_ABORTED   = 3'd7;

  localparam logic [2:0] TOK_OK  = 3'b010;
  localparam logic [2:0] TOK_CRC = 3'b101;
  localparam logic [2:0] TOK_WR  = 3'b110;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16_sync.sv
// CRC16 (x^16+x^12+x^5+1) LFSR, MSB-first; clear beats step, step beats plain shift-out.
module sd_crc16_sync
  import sd_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        step_i,
  input  logic        bit_i,
  input  logic        shift_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_i ^ crc_q[15];
    if (clr_i)
      crc_d = '0;
    else if (step_i)
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    else if (shift_i)
      crc_d = {crc_q[14:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_data_tx_ctrl.sv
// Single-block SD write on DAT0 (1-bit mode): start, data, CRC16, end, CRC-status token, busy wait.
//   state  | meaning
//   IDLE   | line released, waiting for start_i
//   START  | drive start bit (0) on next strobe
//   DATA   | shift out BLKSIZE bytes MSB-first, stepping CRC
//   CRC    | shift out 16 CRC bits, CRC[15] first
//   END    | drive end bit (1)
//   REL    | release DAT0 on next strobe
//   WSTAT  | wait for status start bit, STAT_TMO strobes max
//   STAT   | sample 3 token bits plus end bit
//   BUSY   | wait for card to release busy, BUSY_TMO strobes max
//   DONE   | one-clk done_o pulse with result_o
module sd_data_tx_ctrl
  import sd_tx_pkg::*;
#(
  parameter int unsigned BLKSIZE  = 512,
  parameter int unsigned STAT_TMO = 64,
  parameter int unsigned BUSY_TMO = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sd_clk_en,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  input  logic       sd_dat_i,
  output logic       sd_dat_o,
  output logic       sd_dat_oe,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] result_o
);

  localparam int unsigned NBITS = BLKSIZE * 8;
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned RW    = $clog2(BLKSIZE) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      sub_cnt_q, sub_cnt_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [2:0]      tok_q, tok_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [RW-1:0]   req_q, req_d;
  logic            dat_q, dat_d;
  logic            oe_q, oe_d;
  logic [2:0]      res_q, res_d;

  logic            accept, hold_avail;
  logic [7:0]      hold_eff;
  logic            crc_clr, crc_step, crc_bit, crc_shift;
  logic [15:0]     crc;

  sd_crc16_sync u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (crc_clr),
    .step_i  (crc_step),
    .bit_i   (crc_bit),
    .shift_i (crc_shift),
    .crc_o   (crc)
  );

  assign data_ready_o = ((state_q == S_START) || (state_q == S_DATA)) &&
                        !hold_full_q && (req_q < RW'(BLKSIZE));
  assign accept     = data_valid_i && data_ready_o;
  // A byte handed over in the same clk as a strobe is already usable by that strobe.
  assign hold_avail = hold_full_q || accept;
  assign hold_eff   = accept ? data_i : hold_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    tmo_d       = tmo_q;
    tok_d       = tok_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    req_d       = req_q;
    dat_d       = dat_q;
    oe_d        = oe_q;
    res_d       = res_q;
    crc_clr     = 1'b0;
    crc_step    = 1'b0;
    crc_bit     = 1'b0;
    crc_shift   = 1'b0;

    if (accept) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
      req_d       = req_q + RW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_START;
          crc_clr     = 1'b1;
          res_d       = RES_OK;
          bit_cnt_d   = '0;
          req_d       = '0;
          hold_full_d = 1'b0;
        end
      end
      S_START: begin
        if (sd_clk_en) begin
          dat_d     = 1'b0;
          oe_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (sd_clk_en) begin
          if (bit_cnt_q[2:0] == 3'd0 && !hold_avail) begin
            oe_d    = 1'b0;
            dat_d   = 1'b1;
            res_d   = RES_UNDERRUN;
            state_d = S_DONE;
          end else begin
            crc_step = 1'b1;
            if (bit_cnt_q[2:0] == 3'd0) begin
              dat_d       = hold_eff[7];
              crc_bit     = hold_eff[7];
              sh_d        = {hold_eff[6:0], 1'b0};
              hold_full_d = 1'b0;
            end else begin
              dat_d   = sh_q[7];
              crc_bit = sh_q[7];
              sh_d    = {sh_q[6:0], 1'b0};
            end
            if (bit_cnt_q == BIT_LAST) begin
              sub_cnt_d = '0;
              state_d   = S_CRC;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
      end
      S_CRC: begin
        if (sd_clk_en) begin
          dat_d     = crc[15];
          crc_shift = 1'b1;
          sub_cnt_d = sub_cnt_q + 4'd1;
          if (sub_cnt_q == 4'd15) state_d = S_END;
        end
      end
      S_END: begin
        if (sd_clk_en) begin
          dat_d   = 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (sd_clk_en) begin
          oe_d    = 1'b0;
          tmo_d   = 16'(STAT_TMO);
          state_d = S_WSTAT;
        end
      end
      S_WSTAT: begin
        if (sd_clk_en) begin
          if (!sd_dat_i) begin
            sub_cnt_d = '0;
            state_d   = S_STAT;
          end else if (tmo_q <= 16'd1) begin
            res_d   = RES_STAT_TMO;
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
      end
      S_STAT: begin
        if (sd_clk_en) begin
          sub_cnt_d = sub_cnt_q + 4'd1;
          if (sub_cnt_q < 4'd3) begin
            tok_d = {tok_q[1:0], sd_dat_i};
          end else begin
            state_d = S_DONE;
            if (!sd_dat_i)              res_d = RES_BAD_TOKEN;
            else if (tok_q == TOK_OK) begin
              tmo_d   = 16'(BUSY_TMO);
              state_d = S_BUSY;
            end
            else if (tok_q == TOK_CRC)  res_d = RES_CRC_ERR;
            else if (tok_q == TOK_WR)   res_d = RES_WR_ERR;
            else                        res_d = RES_BAD_TOKEN;
          end
        end
      end
      S_BUSY: begin
        if (sd_clk_en) begin
          if (sd_dat_i) begin
            res_d   = RES_OK;
            state_d = S_DONE;
          end else if (tmo_q <= 16'd1) begin
            res_d   = RES_BUSY_TMO;
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the strobe would have done this clk.
    if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_DONE;
      oe_d      = 1'b0;
      dat_d     = 1'b1;
      res_d     = RES_ABORTED;
      crc_step  = 1'b0;
      crc_shift = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      sub_cnt_q   <= '0;
      tmo_q       <= '0;
      tok_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      req_q       <= '0;
      dat_q       <= 1'b1;
      oe_q        <= 1'b0;
      res_q       <= RES_OK;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      tmo_q       <= tmo_d;
      tok_q       <= tok_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      req_q       <= req_d;
      dat_q       <= dat_d;
      oe_q        <= oe_d;
      res_q       <= res_d;
    end
  end

  assign sd_dat_o  = dat_q;
  assign sd_dat_oe = oe_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign result_o  = res_q;

endmodule

// File: tb/tb_sd_data_tx_ctrl.sv
// Directed bench: a 512-byte instance for the full-size block, a 4-byte instance for error paths.
module tb_sd_data_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, sd_clk_en = 1'b0, data_valid_i = 1'b0, sd_dat_i = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, abort_a = 1'b0, abort_b = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       a_ready, a_dat, a_oe, a_busy, a_done;
  logic       b_ready, b_dat, b_oe, b_busy, b_done;
  logic [2:0] a_res, b_res;

  int total = 0, bad = 0;
  int hs_a = 0, hs_b = 0, done_a = 0, done_b = 0;
  int ones, oe_hi;
  logic [15:0] crc_rx, rx16;
  logic start_bit, end_bit, rel_oe;

  sd_data_tx_ctrl #(.BLKSIZE(512)) u_dut_a (
    .clk(clk), .rst(rst), .sd_clk_en(sd_clk_en), .start_i(start_a), .abort_i(abort_a),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(a_ready),
    .sd_dat_i(sd_dat_i), .sd_dat_o(a_dat), .sd_dat_oe(a_oe),
    .busy_o(a_busy), .done_o(a_done), .result_o(a_res)
  );

  sd_data_tx_ctrl #(.BLKSIZE(4), .STAT_TMO(64), .BUSY_TMO(8)) u_dut_b (
    .clk(clk), .rst(rst), .sd_clk_en(sd_clk_en), .start_i(start_b), .abort_i(abort_b),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(b_ready),
    .sd_dat_i(sd_dat_i), .sd_dat_o(b_dat), .sd_dat_oe(b_oe),
    .busy_o(b_busy), .done_o(b_done), .result_o(b_res)
  );

  always @(posedge clk) begin
    if (data_valid_i && a_ready) hs_a <= hs_a + 1;
    if (data_valid_i && b_ready) hs_b <= hs_b + 1;
    if (a_done) done_a <= done_a + 1;
    if (b_done) done_b <= done_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One idle clk then one strobe clk; returns at the negedge right after the strobe edge.
  task automatic bit_time();
    @(negedge clk); sd_clk_en = 1'b1;
    @(negedge clk); sd_clk_en = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sd_dat_i = v[i];
      bit_time();
    end
  endtask

  // Start a 4-byte block on instance B and run n strobes, capturing the line.
  task automatic tx_block_b(input logic [7:0] d, input int n);
    @(negedge clk);
    data_i = d; data_valid_i = 1'b1; sd_dat_i = 1'b1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    ones = 0; oe_hi = 0; crc_rx = '0;
    for (int k = 0; k < n; k++) begin
      bit_time();
      if (k == 0)       start_bit = b_dat;
      else if (k <= 32) ones = ones + int'(b_dat);
      else if (k <= 48) crc_rx = {crc_rx[14:0], b_dat};
      else if (k == 49) end_bit = b_dat;
      else              rel_oe = b_oe;
      if (k <= 49) oe_hi = oe_hi + int'(b_oe);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dat", a_dat, 1); chk("rst_oe", a_oe, 0); chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0); chk("rst_res", a_res, 0);
    rst = 1'b0;
    @(negedge clk);

    // 512 x 0xFF
    data_i = 8'hFF; data_valid_i = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("a_busy_start", a_busy, 1); chk("a_ready_start", a_ready, 1);
    bit_time();
    chk("a_start_bit", a_dat, 0); chk("a_start_oe", a_oe, 1);
    ones = 0; oe_hi = 0;
    for (int k = 0; k < 4096; k++) begin
      bit_time();
      ones = ones + int'(a_dat); oe_hi = oe_hi + int'(a_oe);
    end
    chk("a_data_ones", ones, 4096); chk("a_data_oe", oe_hi, 4096);
    crc_rx = '0;
    for (int k = 0; k < 16; k++) begin
      bit_time();
      crc_rx = {crc_rx[14:0], a_dat};
    end
    chk("a_crc", crc_rx, 16'h7FA1);
    bit_time();
    chk("a_end_bit", a_dat, 1); chk("a_end_oe", a_oe, 1);
    bit_time();
    chk("a_rel_oe", a_oe, 0);
    send_bits(8'b0110_0101, 7);
    sd_dat_i = 1'b0;
    repeat (10) bit_time();
    chk("a_busy_wait_done", a_done, 0); chk("a_busy_wait_busy", a_busy, 1);
    sd_dat_i = 1'b1;
    bit_time();
    chk("a_done", a_done, 1); chk("a_res", a_res, 0);
    @(negedge clk);
    chk("a_idle", a_busy, 0); chk("a_done_cnt", done_a, 1); chk("a_handshakes", hs_a, 512);

    // 4 x 0x00, CRC-error token
    tx_block_b(8'h00, 51);
    chk("b0_start", start_bit, 0); chk("b0_ones", ones, 0); chk("b0_crc", crc_rx, 16'h0000);
    chk("b0_end", end_bit, 1); chk("b0_oe_hi", oe_hi, 50); chk("b0_rel", rel_oe, 0);
    send_bits(8'b0000_1011, 5);
    chk("b0_done", b_done, 1); chk("b0_res", b_res, 1);
    @(negedge clk);
    chk("b0_idle", b_busy, 0); chk("b0_res_held", b_res, 1);

    // status timeout
    tx_block_b(8'h00, 51);
    sd_dat_i = 1'b1; oe_hi = 0;
    repeat (63) begin
      bit_time();
      oe_hi = oe_hi + int'(b_oe);
    end
    chk("tmo_done_early", b_done, 0); chk("tmo_busy", b_busy, 1);
    bit_time();
    oe_hi = oe_hi + int'(b_oe);
    chk("tmo_done", b_done, 1); chk("tmo_res", b_res, 3); chk("tmo_oe", oe_hi, 0);

    // underrun on third byte
    @(negedge clk);
    data_i = 8'h3C; data_valid_i = 1'b1; sd_dat_i = 1'b1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    bit_time();
    rx16 = '0;
    repeat (2) begin bit_time(); rx16 = {rx16[14:0], b_dat}; end
    data_valid_i = 1'b0; oe_hi = 0;
    repeat (14) begin
      bit_time();
      rx16 = {rx16[14:0], b_dat}; oe_hi = oe_hi + int'(b_oe);
    end
    chk("ur_bits", rx16, 16'h3C3C); chk("ur_oe_before", oe_hi, 14);
    bit_time();
    chk("ur_oe", b_oe, 0); chk("ur_done", b_done, 1); chk("ur_res", b_res, 5);
    oe_hi = 0;
    repeat (20) begin bit_time(); oe_hi = oe_hi + int'(b_oe); end
    chk("ur_no_crc", oe_hi, 0); chk("ur_idle", b_busy, 0);
    data_valid_i = 1'b1;

    // abort together with a strobe mid-CRC, then a clean block
    tx_block_b(8'hFF, 41);
    @(negedge clk); sd_clk_en = 1'b1; abort_b = 1'b1;
    @(negedge clk); sd_clk_en = 1'b0; abort_b = 1'b0;
    chk("ab_oe", b_oe, 0); chk("ab_dat", b_dat, 1); chk("ab_done", b_done, 1); chk("ab_res", b_res, 7);
    tx_block_b(8'h00, 51);
    chk("ab_next_crc", crc_rx, 16'h0000); chk("ab_next_rel", rel_oe, 0);
    send_bits(8'b0000_1011, 6);
    chk("ok_done", b_done, 1); chk("ok_res", b_res, 0);

    // bad token
    tx_block_b(8'h00, 51);
    send_bits(8'b0000_0111, 5);
    chk("bt_done", b_done, 1); chk("bt_res", b_res, 6);

    // busy timeout (8 strobes on instance B)
    tx_block_b(8'h00, 51);
    send_bits(8'b0000_0101, 5);
    sd_dat_i = 1'b0;
    repeat (7) bit_time();
    chk("bto_done_early", b_done, 0); chk("bto_busy", b_busy, 1);
    bit_time();
    chk("bto_done", b_done, 1); chk("bto_res", b_res, 4);

    // start ignored during busy, then reset
    tx_block_b(8'h00, 51);
    send_bits(8'b0000_0101, 5);
    sd_dat_i = 1'b0;
    repeat (3) bit_time();
    @(negedge clk); start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    chk("ign_ready", b_ready, 0); chk("ign_busy", b_busy, 1); chk("ign_oe", b_oe, 0);
    bit_time();
    chk("ign_done", b_done, 0);
    rst = 1'b1; @(negedge clk);
    chk("mr_dat", b_dat, 1); chk("mr_oe", b_oe, 0); chk("mr_ready", b_ready, 0);
    chk("mr_busy", b_busy, 0); chk("mr_done", b_done, 0); chk("mr_res", b_res, 0);
    rst = 1'b0; sd_dat_i = 1'b1;
    repeat (5) bit_time();
    chk("b_done_cnt", done_b, 7); chk("b_handshakes", hs_b, 30); chk("b_final_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
